// File: rtl/uart_baud_pkg.sv
// uart_baud_pkg: shared baud codes, nominal bit widths, ladder thresholds and FSM states
package uart_baud_pkg;
  localparam int MAX_COUNT_DEF = 666666;
  localparam int MIN_COUNT_DEF = 55;
  localparam logic [3:0] BAUD_300 = 4'd0, BAUD_1200 = 4'd1, BAUD_2400 = 4'd2, BAUD_4800 = 4'd3;
  localparam logic [3:0] BAUD_9600 = 4'd4, BAUD_19200 = 4'd5, BAUD_38400 = 4'd6, BAUD_57600 = 4'd7;
  localparam logic [3:0] BAUD_115200 = 4'd8, BAUD_230400 = 4'd9, BAUD_460800 = 4'd10, BAUD_921600 = 4'd11;
  localparam logic [19:0] NOM [12] = '{20'd333333, 20'd83333, 20'd41667, 20'd20833, 20'd10417, 20'd5208,
                                       20'd2604, 20'd1736, 20'd868, 20'd434, 20'd217, 20'd109};
  // THR[i] is the midpoint between NOM[i] and NOM[i+1]; equality selects code i (the slower rate)
  localparam logic [19:0] THR [11] = '{20'd208333, 20'd62500, 20'd31250, 20'd15625, 20'd7812, 20'd3906,
                                       20'd2170, 20'd1302, 20'd651, 20'd325, 20'd163};
  typedef enum logic [2:0] {ARMED, MEASURE, CLASSIFY, LOCKED, BREAK} state_e;
endpackage

// File: rtl/baud_classify.sv
// baud_classify: maps a measured low width to a baud code, flagging too-short pulses
module baud_classify
  import uart_baud_pkg::*;
#(
  parameter int MIN_COUNT = MIN_COUNT_DEF
) (
  input  logic [19:0] w_i,
  output logic [3:0]  code_o,
  output logic        glitch_o
);
  // scanning from the fastest threshold upward leaves the slowest matching rate
  always_comb begin
    code_o = BAUD_921600;
    for (int i = 10; i >= 0; i--)
      if (w_i >= THR[i]) code_o = 4'(i);
  end
  assign glitch_o = w_i < 20'(MIN_COUNT);
endmodule

// File: rtl/uart_autobaud_detect.sv
// uart_autobaud_detect: measures the first start-bit low width on rx and locks a baud code
module uart_autobaud_detect
  import uart_baud_pkg::*;
#(
  parameter int MAX_COUNT = MAX_COUNT_DEF,
  parameter int MIN_COUNT = MIN_COUNT_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx,
  input  logic        restart,
  output logic [3:0]  baud,
  output logic        baud_valid,
  output logic        locked,
  output logic        err,
  output logic [19:0] measured_count
);
  localparam logic [19:0] MAX_W = 20'(MAX_COUNT);
  state_e      state_q;
  logic        s1_q, rx_s_q, rx_p_q;
  logic [19:0] cnt_q, meas_q, cnt_inc;
  logic [3:0]  baud_q, code;
  logic        valid_q, locked_q, err_q, glitch;
  baud_classify #(.MIN_COUNT(MIN_COUNT)) u_cls (.w_i(meas_q), .code_o(code), .glitch_o(glitch));
  assign cnt_inc = (cnt_q == MAX_W) ? cnt_q : cnt_q + 20'd1;
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ARMED;
      s1_q     <= 1'b1;
      rx_s_q   <= 1'b1;
      rx_p_q   <= 1'b1;
      cnt_q    <= '0;
      meas_q   <= '0;
      baud_q   <= BAUD_300;
      valid_q  <= 1'b0;
      locked_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      s1_q    <= rx;
      rx_s_q  <= s1_q;
      rx_p_q  <= rx_s_q;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      if (restart) begin
        state_q  <= ARMED;
        locked_q <= 1'b0;
        cnt_q    <= '0;
      end else begin
        case (state_q)
          ARMED: if (rx_p_q && !rx_s_q) begin
            cnt_q   <= 20'd1;
            state_q <= MEASURE;
          end
          MEASURE: if (rx_s_q) begin
            meas_q  <= cnt_q;
            state_q <= CLASSIFY;
          end else begin
            cnt_q <= cnt_inc;
            if (cnt_inc == MAX_W) begin
              err_q   <= 1'b1;
              state_q <= BREAK;
            end
          end
          CLASSIFY: if (glitch) state_q <= ARMED;
          else begin
            baud_q   <= code;
            locked_q <= 1'b1;
            valid_q  <= 1'b1;
            state_q  <= LOCKED;
          end
          BREAK: if (rx_s_q) state_q <= ARMED;
          default: ;
        endcase
      end
    end
  end
  assign baud           = baud_q;
  assign baud_valid     = valid_q;
  assign locked         = locked_q;
  assign err            = err_q;
  assign measured_count = meas_q;
endmodule

// File: tb/tb_uart_autobaud_detect.sv
// tb_uart_autobaud_detect: directed checks of width measurement, ladder boundaries, timeout and restart
module tb_uart_autobaud_detect;
  logic        clk = 1'b0, reset = 1'b1, rx = 1'b1, restart = 1'b0;
  logic [3:0]  baud;
  logic        baud_valid, locked, err;
  logic [19:0] measured_count;
  int n_chk = 0, n_pass = 0, vcnt = 0, ecnt = 0;

  // timeout shortened so the break path fits a short run; the ladder itself is unchanged
  uart_autobaud_detect #(.MAX_COUNT(20000)) dut (
    .clk(clk), .reset(reset), .rx(rx), .restart(restart), .baud(baud),
    .baud_valid(baud_valid), .locked(locked), .err(err), .measured_count(measured_count)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (baud_valid) vcnt++;
    if (err) ecnt++;
  end

  task automatic chk(input string tag, input longint got, input longint exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic do_restart();
    @(negedge clk) restart = 1'b1;
    @(negedge clk) restart = 1'b0;
  endtask

  task automatic pulse(input int w);
    @(negedge clk) rx = 1'b0;
    repeat (w) @(negedge clk);
    rx = 1'b1;
  endtask

  task automatic run(input int w, input int code);
    int v0;
    do_restart();
    v0 = vcnt;
    pulse(w);
    repeat (6) @(negedge clk);
    chk($sformatf("baud w=%0d", w), baud, code);
    chk($sformatf("locked w=%0d", w), locked, 1);
    chk($sformatf("valid w=%0d", w), vcnt - v0, 1);
    chk($sformatf("meas w=%0d", w), measured_count, w);
  endtask

  initial begin
    int v0, e0, eidx;
    logic [3:0] b0;
    logic [19:0] m0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst baud", baud, 0);
    chk("rst valid", baud_valid, 0);
    chk("rst locked", locked, 0);
    chk("rst err", err, 0);
    chk("rst meas", measured_count, 0);
    // basic 115200 measurement
    run(868, 8);
    chk("t1 err", ecnt, 0);
    // ladder boundaries
    run(651, 8);
    run(650, 9);
    run(163, 10);
    run(162, 11);
    run(3906, 5);
    run(3905, 6);
    run(55, 11);
    do_restart();
    v0 = vcnt;
    pulse(54);
    repeat (6) @(negedge clk);
    chk("glitch54 valid", vcnt - v0, 0);
    chk("glitch54 locked", locked, 0);
    chk("glitch54 baud", baud, 11);
    // glitch followed by a real 9600 start bit, with no restart in between
    do_restart();
    v0 = vcnt;
    pulse(40);
    repeat (10) @(negedge clk);
    chk("glitch40 valid", vcnt - v0, 0);
    pulse(10417);
    repeat (6) @(negedge clk);
    chk("t3 baud", baud, 4);
    chk("t3 valid", vcnt - v0, 1);
    chk("t3 locked", locked, 1);
    // timeout: err appears two sync cycles after cnt would reach the limit
    do_restart();
    v0 = vcnt;
    e0 = ecnt;
    eidx = 0;
    b0 = baud;
    @(negedge clk) rx = 1'b0;
    for (int i = 1; i <= 22000; i++) begin
      @(negedge clk);
      if (err && eidx == 0) eidx = i;
    end
    chk("t4 err cycle", eidx, 20002);
    chk("t4 err count", ecnt - e0, 1);
    chk("t4 locked", locked, 0);
    chk("t4 valid", vcnt - v0, 0);
    chk("t4 baud hold", baud, b0);
    rx = 1'b1;
    repeat (5) @(negedge clk);
    pulse(5208);
    repeat (6) @(negedge clk);
    chk("t4 rearm baud", baud, 5);
    chk("t4 rearm valid", vcnt - v0, 1);
    // restart mid-measure drops that measurement
    do_restart();
    v0 = vcnt;
    @(negedge clk) rx = 1'b0;
    repeat (300) @(negedge clk);
    restart = 1'b1;
    @(negedge clk) restart = 1'b0;
    repeat (200) @(negedge clk);
    rx = 1'b1;
    repeat (8) @(negedge clk);
    chk("t5 dropped valid", vcnt - v0, 0);
    chk("t5 dropped locked", locked, 0);
    pulse(109);
    repeat (6) @(negedge clk);
    chk("t5 baud", baud, 11);
    chk("t5 valid", vcnt - v0, 1);
    // restart landing on the classify cycle suppresses the result
    do_restart();
    v0 = vcnt;
    pulse(868);
    repeat (3) @(negedge clk);
    restart = 1'b1;
    @(negedge clk) restart = 1'b0;
    repeat (6) @(negedge clk);
    chk("t5 cls valid", vcnt - v0, 0);
    chk("t5 cls locked", locked, 0);
    chk("t5 cls baud", baud, 11);
    // once locked, rx activity is ignored
    run(434, 9);
    v0 = vcnt;
    m0 = measured_count;
    for (int i = 0; i < 6; i++) begin
      pulse($urandom_range(1, 300));
      repeat ($urandom_range(1, 50)) @(negedge clk);
    end
    repeat (6) @(negedge clk);
    chk("t6 lock baud", baud, 9);
    chk("t6 lock locked", locked, 1);
    chk("t6 lock valid", vcnt - v0, 0);
    chk("t6 lock meas", measured_count, m0);
    // reset mid-measure
    do_restart();
    @(negedge clk) rx = 1'b0;
    repeat (100) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("t6 rst baud", baud, 0);
    chk("t6 rst locked", locked, 0);
    chk("t6 rst meas", measured_count, 0);
    reset = 1'b0;
    rx = 1'b1;
    repeat (5) @(negedge clk);
    run(217, 10);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
